// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing constants (default 640x480@60) and helpers for the sync generator.
// Every resolution select in the top level is fed from these same values.
package vga_sync_gen_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned DEF_H_VIS  = 640;
  localparam int unsigned DEF_H_FP   = 16;
  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP   = 48;
  localparam int unsigned DEF_V_VIS  = 480;
  localparam int unsigned DEF_V_FP   = 10;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 33;

  localparam int unsigned H_TOTAL  = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL  = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned HS_START = DEF_H_VIS + DEF_H_FP;
  localparam int unsigned HS_END   = HS_START + DEF_H_SYNC;
  localparam int unsigned VS_START = DEF_V_VIS + DEF_V_FP;
  localparam int unsigned VS_END   = VS_START + DEF_V_SYNC;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             sync;
    logic             visible;
  } axis_t;

  // Half-open window test lo <= v < hi.
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input int unsigned      lo,
                                     input int unsigned      hi);
    int unsigned vw;
    vw = {{(32-CNT_W){1'b0}}, v};
    return (vw >= lo) && (vw < hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_axis_counter.sv
// One timing axis: wrapping position counter plus registered sync pin.
// sync is loaded from the next-state count so it lines up with cnt in the same cycle.
module vga_axis_counter
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned VIS  = DEF_H_VIS,
  parameter int unsigned FP   = DEF_H_FP,
  parameter int unsigned SYNC = DEF_H_SYNC,
  parameter int unsigned BP   = DEF_H_BP,
  parameter bit          POL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             sync,
  output logic             wrap,
  output logic             visible
);

  localparam int unsigned TOTAL   = VIS + FP + SYNC + BP;
  localparam int unsigned S_START = VIS + FP;
  localparam int unsigned S_END   = S_START + SYNC;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_C = CNT_W'(VIS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_q, sync_d;

  // >= so that any stray out-of-range value still returns to 0 on the next step
  assign wrap = (cnt_q >= LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (step) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
    sync_d = in_window(cnt_d, S_START, S_END) ? POL : ~POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sync_q <= ~POL;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign cnt     = cnt_q;
  assign sync    = sync_q;
  assign visible = (cnt_q < VIS_C);

endmodule

// File: rtl/vga_sync_gen.sv
// Pixel-timing generator: x/y counters, hsync/vsync pins and line/frame strobes.
// vsync drives the graphics_engine animation clock, so it comes straight from a flop.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned H_VIS  = DEF_H_VIS,
  parameter int unsigned H_FP   = DEF_H_FP,
  parameter int unsigned H_SYNC = DEF_H_SYNC,
  parameter int unsigned H_BP   = DEF_H_BP,
  parameter int unsigned V_VIS  = DEF_V_VIS,
  parameter int unsigned V_FP   = DEF_V_FP,
  parameter int unsigned V_SYNC = DEF_V_SYNC,
  parameter int unsigned V_BP   = DEF_V_BP,
  parameter bit          H_POL  = 1'b0,
  parameter bit          V_POL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_active,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
);

  axis_t h_ax, v_ax;
  logic  h_wrap;
  logic  v_wrap_unused;

  vga_axis_counter #(
    .VIS (H_VIS),
    .FP  (H_FP),
    .SYNC(H_SYNC),
    .BP  (H_BP),
    .POL (H_POL)
  ) u_h (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (pix_en),
    .cnt    (h_ax.cnt),
    .sync   (h_ax.sync),
    .wrap   (h_wrap),
    .visible(h_ax.visible)
  );

  // The vertical axis steps once per line, on the same edge where x wraps
  vga_axis_counter #(
    .VIS (V_VIS),
    .FP  (V_FP),
    .SYNC(V_SYNC),
    .BP  (V_BP),
    .POL (V_POL)
  ) u_v (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (pix_en & h_wrap),
    .cnt    (v_ax.cnt),
    .sync   (v_ax.sync),
    .wrap   (v_wrap_unused),
    .visible(v_ax.visible)
  );

  assign x            = h_ax.cnt;
  assign y            = v_ax.cnt;
  assign hsync        = h_ax.sync;
  assign vsync        = v_ax.sync;
  assign frame_active = h_ax.visible & v_ax.visible;
  assign line_start   = (h_ax.cnt == '0);
  assign frame_start  = (h_ax.cnt == '0) && (v_ax.cnt == '0);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing, a reduced active-low timing
// (H 16/4/6/4, V 6/2/2/2) and a reduced active-high timing (H 8/2/2/2, V 4/1/1/1).
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default 640x480 instance
  logic       rst_d, en_d;
  logic [9:0] x_d, y_d;
  logic       fa_d, hs_d, vs_d, ls_d, fs_d;
  // reduced timing, active-low syncs: H_TOTAL 30 (hs 20..25), V_TOTAL 12 (vs 8..9)
  logic       rst_m, en_m;
  logic [9:0] x_m, y_m;
  logic       fa_m, hs_m, vs_m, ls_m, fs_m;
  // small timing, active-high syncs: H_TOTAL 14 (hs 10..11), V_TOTAL 7 (vs 5)
  logic       rst_s, en_s;
  logic [9:0] x_s, y_s;
  logic       fa_s, hs_s, vs_s, ls_s, fs_s;

  vga_sync_gen dut_d (
    .clk(clk), .rst_n(rst_d), .pix_en(en_d), .x(x_d), .y(y_d), .frame_active(fa_d),
    .hsync(hs_d), .vsync(vs_d), .line_start(ls_d), .frame_start(fs_d)
  );

  vga_sync_gen #(
    .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .H_POL(1'b0), .V_POL(1'b0)
  ) dut_m (
    .clk(clk), .rst_n(rst_m), .pix_en(en_m), .x(x_m), .y(y_m), .frame_active(fa_m),
    .hsync(hs_m), .vsync(vs_m), .line_start(ls_m), .frame_start(fs_m)
  );

  vga_sync_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_s), .pix_en(en_s), .x(x_s), .y(y_s), .frame_active(fa_s),
    .hsync(hs_s), .vsync(vs_s), .line_start(ls_s), .frame_start(fs_s)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n_ls, n_hs, n_vs, n_fa, n_fs, bad;
    logic       prev_vs;
    logic [9:0] px, py;

    rst_d = 1'b0; en_d = 1'b1;
    rst_m = 1'b0; en_m = 1'b1;
    rst_s = 1'b0; en_s = 1'b1;

    // 1: reset values, then release and count 1,2,3
    run(2);
    check("rst_x", x_d, 0);
    check("rst_y", y_d, 0);
    check("rst_hsync", hs_d, 1);
    check("rst_vsync", vs_d, 1);
    check("rst_frame_start", fs_d, 1);
    check("rst_line_start", ls_d, 1);
    check("rst_frame_active", fa_d, 1);
    rst_d = 1'b1;
    run(1); check("rel_x1", x_d, 1);
    run(1); check("rel_x2", x_d, 2);
    run(1); check("rel_x3", x_d, 3);
    check("rel_frame_start", fs_d, 0);
    check("rel_y", y_d, 0);

    // 2: one line of default timing
    run(652); check("x655", x_d, 655); check("hs_before", hs_d, 1);
    run(1);   check("x656", x_d, 656); check("hs_fall", hs_d, 0);
    run(95);  check("x751", x_d, 751); check("hs_held", hs_d, 0);
    run(1);   check("x752", x_d, 752); check("hs_rise", hs_d, 1);
    run(47);  check("x799", x_d, 799); check("y_before_wrap", y_d, 0);
    run(1);
    check("wrap_x", x_d, 0);
    check("wrap_y", y_d, 1);
    check("wrap_line_start", ls_d, 1);
    check("wrap_frame_start", fs_d, 0);
    check("line1_vsync", vs_d, 1);
    n_ls = 0; n_hs = 0;
    for (int i = 0; i < 800; i++) begin
      run(1);
      if (ls_d) n_ls++;
      if (!hs_d) n_hs++;
    end
    check("line_start_count", n_ls, 1);
    check("hsync_low_count", n_hs, 96);

    // 3: full frame on the reduced timing (30x12 = 360 clocks)
    check("m_rst_fs", fs_m, 1);
    rst_m = 1'b1;
    n_vs = 0; n_fa = 0; n_fs = 0; bad = 0; prev_vs = vs_m;
    for (int i = 0; i < 360; i++) begin
      run(1);
      if (!vs_m) n_vs++;
      if (fa_m) n_fa++;
      if (fs_m) n_fs++;
      if (vs_m !== prev_vs && x_m != 10'd0) bad++;
      prev_vs = vs_m;
    end
    check("m_vsync_low_clocks", n_vs, 60);
    check("m_active_clocks", n_fa, 96);
    check("m_frame_start_count", n_fs, 1);
    check("m_vsync_edge_off_x0", bad, 0);
    check("m_frame_x", x_m, 0);
    check("m_frame_y", y_m, 0);
    check("m_frame_fs", fs_m, 1);
    check("m_frame_vs", vs_m, 1);

    // 4: 1-of-2 enable, frame takes 720 clocks
    n_fs = 0; n_ls = 0; bad = 0;
    for (int i = 0; i < 720; i++) begin
      en_m = (i % 2 == 0);
      px = x_m; py = y_m;
      run(1);
      if (!en_m && (x_m !== px || y_m !== py)) bad++;
      if (fs_m) n_fs++;
      if (ls_m) n_ls++;
    end
    check("half_hold_violations", bad, 0);
    check("half_frame_start_clocks", n_fs, 2);
    check("half_line_start_clocks", n_ls, 24);
    check("half_end_x", x_m, 0);
    check("half_end_y", y_m, 0);

    // 5: async reset mid-sync at (22,9)
    en_m = 1'b1;
    run(292);
    check("mid_x", x_m, 22);
    check("mid_y", y_m, 9);
    check("mid_hs", hs_m, 0);
    check("mid_vs", vs_m, 0);
    #2 rst_m = 1'b0;
    #1;
    check("async_hs", hs_m, 1);
    check("async_vs", vs_m, 1);
    check("async_x", x_m, 0);
    check("async_y", y_m, 0);
    check("async_fs", fs_m, 1);
    run(1);
    rst_m = 1'b1;
    run(1);
    check("restart_x", x_m, 1);
    check("restart_y", y_m, 0);

    // 6: active-high polarity, small timing
    check("s_rst_hs", hs_s, 0);
    check("s_rst_vs", vs_s, 0);
    rst_s = 1'b1;
    n_hs = 0; n_vs = 0; n_fa = 0; n_fs = 0; bad = 0;
    for (int i = 0; i < 98; i++) begin
      run(1);
      if (hs_s) begin
        n_hs++;
        if (x_s != 10'd10 && x_s != 10'd11) bad++;
      end
      if (vs_s) begin
        n_vs++;
        if (y_s != 10'd5) bad++;
      end
      if (fa_s) n_fa++;
      if (fs_s) n_fs++;
    end
    check("s_hs_high_clocks", n_hs, 14);
    check("s_vs_high_clocks", n_vs, 14);
    check("s_sync_position_violations", bad, 0);
    check("s_active_clocks", n_fa, 32);
    check("s_frame_start_count", n_fs, 1);
    check("s_end_x", x_s, 0);
    check("s_end_y", y_s, 0);
    run(13); check("s_x13", x_s, 13);
    run(1);  check("s_wrap_x", x_s, 0); check("s_wrap_y", y_s, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
